// File: rtl/ysyx_23060111_wbu_pkg.sv
// Shared definitions for the write-back unit: default widths and the
// encoding used to name the two result channels.
package ysyx_23060111_wbu_pkg;

    localparam int ADDR_WIDTH_DEF = 5;
    localparam int DATA_WIDTH_DEF = 32;

    // Result channel select: ALU results are channel 0, loads channel 1.
    typedef enum logic {
        CH_EXU = 1'b0,
        CH_LSU = 1'b1
    } ch_sel_e;

endpackage

// File: rtl/ysyx_23060111_scoreboard.sv
// Register scoreboard: one busy bit per architectural register.
// Bit 0 is hard-wired clear. A set and a clear of the same index in the
// same cycle leaves the bit set (the new producer is still outstanding).
module ysyx_23060111_scoreboard #(
    parameter int ADDR_WIDTH = 5
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  set_en,
    input  logic [ADDR_WIDTH-1:0] set_idx,
    input  logic                  clr_en,
    input  logic [ADDR_WIDTH-1:0] clr_idx,
    input  logic [ADDR_WIDTH-1:0] rs1,
    input  logic [ADDR_WIDTH-1:0] rs2,
    output logic                  rs1_busy,
    output logic                  rs2_busy
);

    localparam int NREG = 1 << ADDR_WIDTH;

    logic [NREG-1:0] busy_reg;

    // x0 never has an outstanding producer.
    assign busy_reg[0] = 1'b0;

    generate
        for (genvar gi = 1; gi < NREG; gi++) begin : g_busy
            // Per-register busy bit: set has priority over clear.
            always_ff @(posedge clk or posedge rst) begin
                if (rst) begin
                    busy_reg[gi] <= 1'b0;
                end else if (set_en && set_idx == ADDR_WIDTH'(gi)) begin
                    busy_reg[gi] <= 1'b1;
                end else if (clr_en && clr_idx == ADDR_WIDTH'(gi)) begin
                    busy_reg[gi] <= 1'b0;
                end
            end
        end
    endgenerate

    assign rs1_busy = busy_reg[rs1];
    assign rs2_busy = busy_reg[rs2];

endmodule

// File: rtl/ysyx_23060111_wbu.sv
// Write-back unit: arbitrates ALU and load results onto a single
// register-file write port, counts retired results and tracks pending
// destinations in a scoreboard.
// Optional feature: define YSYX_23060111_WBU_BYPASS_EN to forward the
// registered write data to the decode source lookups (adds rs1_fwd/rs2_fwd).
module ysyx_23060111_wbu
    import ysyx_23060111_wbu_pkg::*;
#(
    parameter int ADDR_WIDTH = ADDR_WIDTH_DEF,
    parameter int DATA_WIDTH = DATA_WIDTH_DEF
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  exu_valid,
    output logic                  exu_ready,
    input  logic [ADDR_WIDTH-1:0] exu_rd,
    input  logic [DATA_WIDTH-1:0] exu_data,
    input  logic                  lsu_valid,
    output logic                  lsu_ready,
    input  logic [ADDR_WIDTH-1:0] lsu_rd,
    input  logic [DATA_WIDTH-1:0] lsu_data,
    input  logic                  issue_valid,
    input  logic [ADDR_WIDTH-1:0] issue_rd,
    input  logic [ADDR_WIDTH-1:0] rs1,
    input  logic [ADDR_WIDTH-1:0] rs2,
    output logic                  rs1_busy,
    output logic                  rs2_busy,
`ifdef YSYX_23060111_WBU_BYPASS_EN
    output logic [DATA_WIDTH-1:0] rs1_fwd,
    output logic [DATA_WIDTH-1:0] rs2_fwd,
`endif
    output logic                  wen,
    output logic [ADDR_WIDTH-1:0] waddr,
    output logic [DATA_WIDTH-1:0] wdata,
    output logic [31:0]           retire_cnt
);

    ch_sel_e               prio_reg;   // channel that wins the next contention
    logic                  contention;
    logic                  exu_fire;
    logic                  lsu_fire;
    logic                  fire;
    logic [ADDR_WIDTH-1:0] xfer_rd;
    logic [DATA_WIDTH-1:0] xfer_data;
    logic                  wen_reg;
    logic [ADDR_WIDTH-1:0] waddr_reg;
    logic [DATA_WIDTH-1:0] wdata_reg;
    logic [31:0]           cnt_reg;
    logic                  sb_rs1_busy;
    logic                  sb_rs2_busy;

    assign contention = exu_valid & lsu_valid;

    // Each ready looks only at the other channel's valid, so a lone valid
    // channel is always accepted and under contention only the favoured one is.
    assign exu_ready = !rst && (!lsu_valid || prio_reg == CH_EXU);
    assign lsu_ready = !rst && (!exu_valid || prio_reg == CH_LSU);

    assign exu_fire  = exu_valid & exu_ready;
    assign lsu_fire  = lsu_valid & lsu_ready;
    assign fire      = exu_fire | lsu_fire;
    assign xfer_rd   = lsu_fire ? lsu_rd   : exu_rd;
    assign xfer_data = lsu_fire ? lsu_data : exu_data;

    // Round-robin flag: flips only when both channels compete.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            prio_reg <= CH_LSU;
        end else if (contention) begin
            prio_reg <= (prio_reg == CH_LSU) ? CH_EXU : CH_LSU;
        end
    end

    // Registered write port and retire counter; wen is a one-cycle pulse.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wen_reg   <= 1'b0;
            waddr_reg <= '0;
            wdata_reg <= '0;
            cnt_reg   <= '0;
        end else begin
            wen_reg <= fire && (xfer_rd != '0);
            if (fire) begin
                waddr_reg <= xfer_rd;
                wdata_reg <= xfer_data;
                cnt_reg   <= cnt_reg + 32'd1;
            end
        end
    end

    assign wen        = wen_reg;
    assign waddr      = waddr_reg;
    assign wdata      = wdata_reg;
    assign retire_cnt = cnt_reg;

    ysyx_23060111_scoreboard #(
        .ADDR_WIDTH(ADDR_WIDTH)
    ) u_scoreboard (
        .clk     (clk),
        .rst     (rst),
        .set_en  (issue_valid),
        .set_idx (issue_rd),
        .clr_en  (fire),
        .clr_idx (xfer_rd),
        .rs1     (rs1),
        .rs2     (rs2),
        .rs1_busy(sb_rs1_busy),
        .rs2_busy(sb_rs2_busy)
    );

`ifdef YSYX_23060111_WBU_BYPASS_EN
    logic rs1_hit;
    logic rs2_hit;

    // A source matching the value being written this cycle can take it directly.
    assign rs1_hit  = wen_reg && (waddr_reg == rs1);
    assign rs2_hit  = wen_reg && (waddr_reg == rs2);
    assign rs1_busy = sb_rs1_busy && !rs1_hit;
    assign rs2_busy = sb_rs2_busy && !rs2_hit;
    assign rs1_fwd  = rs1_hit ? wdata_reg : '0;
    assign rs2_fwd  = rs2_hit ? wdata_reg : '0;
`else
    assign rs1_busy = sb_rs1_busy;
    assign rs2_busy = sb_rs2_busy;
`endif

endmodule

// File: doc/ysyx_23060111_wbu.md
YSYX_23060111_WBU -- requirements
Module: ysyx_23060111_wbu

Interface
REQ-001 SHALL have parameter ADDR_WIDTH, default 5, register index width.
REQ-002 SHALL have parameter DATA_WIDTH, default 32, result data width.
REQ-003 SHALL have port clk  input  1  sole clock; all state changes on its rising edge.
REQ-004 SHALL have port rst  input  1  reset, asynchronous and active-high.
REQ-005 SHALL have ports exu_valid/exu_ready  input/output  1/1  ALU result handshake.
REQ-006 SHALL have ports exu_rd, exu_data  input  ADDR_WIDTH, DATA_WIDTH  ALU destination index and result.
REQ-007 SHALL have ports lsu_valid/lsu_ready  input/output  1/1  load result handshake.
REQ-008 SHALL have ports lsu_rd, lsu_data  input  ADDR_WIDTH, DATA_WIDTH  load destination index and data.
REQ-009 SHALL have ports issue_valid, issue_rd  input  1, ADDR_WIDTH  decode marks rd as pending.
REQ-010 SHALL have ports rs1, rs2  input  ADDR_WIDTH  decode source indices.
REQ-011 SHALL have ports rs1_busy, rs2_busy  output  1  source has an outstanding producer.
REQ-012 SHALL have ports wen, waddr, wdata  output  1, ADDR_WIDTH, DATA_WIDTH  register-file write port.
REQ-013 SHALL have port retire_cnt  output  32  count of accepted results.

Function
REQ-014 Handshake: a transfer SHALL occur on a channel in a cycle where valid and ready are both high at the rising edge of clk.
REQ-015 Only one channel SHALL be granted per cycle; ready SHALL be high only for the granted channel and SHALL not depend on that channel's own valid.
REQ-016 Arbitration: a single valid channel SHALL be granted; when both are valid, the channel not granted at the previous contention SHALL win; the flag SHALL update only on contention.
REQ-017 Latency: a transfer at edge N SHALL present wen=1, waddr=rd, wdata=data during cycle N+1 (registered output, one cycle wide).
REQ-018 A transfer with rd==0 SHALL produce wen=0 but SHALL still increment retire_cnt and still complete normally.
REQ-019 retire_cnt SHALL increment by 1 per transfer and wrap from 0xFFFFFFFF to 0.
REQ-020 Scoreboard: one busy bit per register; issue_valid with issue_rd!=0 SHALL set busy[issue_rd]; the transfer of rd SHALL clear busy[rd] at the same edge that loads the output register.
REQ-021 Simultaneous set and clear of the same index SHALL leave the bit set.
REQ-022 busy[0] SHALL be constant 0; rs1_busy/rs2_busy SHALL be combinational lookups of the current busy bits.
REQ-023 Back-to-back transfers SHALL be sustained at one per cycle without bubbles.

Reset
REQ-024 While rst=1: wen=0, waddr=0, wdata=0, retire_cnt=0, all busy bits=0, and the arbitration flag SHALL favour LSU.
REQ-025 Reset mid-operation SHALL discard any pending write (no wen after deassertion).
REQ-026 exu_ready and lsu_ready SHALL be 0 while rst=1.

Configuration
REQ-027 Macro YSYX_23060111_WBU_BYPASS_EN defined: rs1_busy/rs2_busy SHALL read 0 for an index equal to waddr while wen=1, and outputs rs1_fwd, rs2_fwd (DATA_WIDTH) SHALL carry wdata on such a hit, else 0.
REQ-028 Macro undefined: no forwarding logic and no rs1_fwd/rs2_fwd ports; busy reflects the scoreboard only.

Structure
REQ-029 Shared package SHALL hold the ADDR_WIDTH/DATA_WIDTH defaults and the channel-select encoding (EXU=0, LSU=1).
REQ-030 Scoreboard SHALL be a sub-module ysyx_23060111_scoreboard (set/clear/query ports); arbitration and output register live in the top.

Verification
REQ-031 Single EXU: exu_valid=1, rd=5, data=0x1234 at edge N -> wen=1, waddr=5, wdata=0x1234 in cycle N+1, retire_cnt=1.
REQ-032 Contention: both valid for 4 cycles after reset -> grants LSU, EXU, LSU, EXU; 4 writes, no bubble.
REQ-033 Scoreboard: issue rd=7, then rs1=7 -> rs1_busy=1 until the rd=7 transfer edge, 0 afterwards; issue and transfer of rd=7 at the same edge -> stays 1.
REQ-034 x0: transfer rd=0, data=0xFFFF -> wen=0, retire_cnt increments; issue_rd=0 -> rs1=0 never busy.
REQ-035 Reset mid-flow: rst asserted the cycle after a transfer -> wen=0 immediately, busy all 0, retire_cnt=0.
REQ-036 With YSYX_23060111_WBU_BYPASS_EN: wen=1, waddr=9, wdata=0xAB, rs2=9 -> rs2_busy=0, rs2_fwd=0xAB.
